ram_arb: RTL and testbench

Two-requester arbiter for the shared data-RAM port. It multiplexes the CPU load/store port and the UART debug loader onto a single synchronous RAM port, with round-robin fairness, a burst cap and a debug lock. Read data comes back one cycle after the accepted request, routed to its owner. It sits between the CPU/loader and `dram`, replacing tri-state port sharing with explicit request/grant handshakes.

---
 rtl/ram_arb_pkg.sv | 16 +
 rtl/ram_arb_rr_pick2.sv | 35 +++
 rtl/ram_arb.sv | 113 +++++++++++
 tb/tb_ram_arb.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types for the data-RAM port arbiter: requester identity and the
// request bundle that is steered onto the RAM port.
package ram_arb_pkg;

    localparam int DATA_W = 32;

    typedef enum logic {OWN_CPU, OWN_DBG} owner_t;

    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wr_data;
        logic [3:0]        byte_en;
    } ram_req_t;

endpackage

// File: rtl/ram_arb_rr_pick2.sv
// Combinational two-way picker: round-robin with a burst cap, plus a lock that
// keeps the port with the debug loader once it owns it.
module rr_pick2
    import ram_arb_pkg::*;
#(
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 4
) (
    input  logic             c,
    input  logic             d,
    input  owner_t           last_owner,
    input  logic [CNT_W-1:0] burst_cnt,
    input  logic             lock,
    output logic             vld,
    output owner_t           winner
);

    always_comb begin
        // NOTE: every output gets a default before the branches so no path
        // leaves it unassigned, which would otherwise infer a latch.
        vld    = c | d;
        winner = OWN_DBG;
        if (c && d) begin
            if (last_owner == OWN_DBG && lock)
                winner = OWN_DBG;
            else if (burst_cnt < CNT_W'(MAX_BURST))
                winner = last_owner;
            else
                winner = (last_owner == OWN_CPU) ? OWN_DBG : OWN_CPU;
        end else if (c) begin
            winner = OWN_CPU;
        end
    end

endmodule

// File: rtl/ram_arb.sv
// Arbitrates the CPU load/store port and the UART debug loader onto one
// synchronous RAM port; read data returns one cycle after the grant.
module ram_arb
    import ram_arb_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MAX_BURST = 8
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            cpu_rst_n_i,
    input  logic            dbg_lock_i,
    input  logic            cpu_req_i,
    input  logic            dbg_req_i,
    input  logic            cpu_we_i,
    input  logic            dbg_we_i,
    input  logic [XLEN-1:0] cpu_addr_i,
    input  logic [XLEN-1:0] dbg_addr_i,
    input  logic [XLEN-1:0] cpu_wr_data_i,
    input  logic [XLEN-1:0] dbg_wr_data_i,
    input  logic [3:0]      cpu_byte_en_i,
    input  logic [3:0]      dbg_byte_en_i,
    output logic            cpu_gnt_o,
    output logic            dbg_gnt_o,
    output logic            cpu_rd_vld_o,
    output logic            dbg_rd_vld_o,
    output logic [XLEN-1:0] cpu_rd_data_o,
    output logic [XLEN-1:0] dbg_rd_data_o,
    output logic [XLEN-1:0] ram_rd_addr_o,
    output logic [XLEN-1:0] ram_wr_addr_o,
    output logic [XLEN-1:0] ram_wr_data_o,
    output logic [3:0]      ram_wr_byte_en_o,
    input  logic [XLEN-1:0] ram_rd_data_i
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    logic             arb_en;
    owner_t           last_owner;
    logic [CNT_W-1:0] burst_cnt;
    logic [1:0]       rd_pend;

    logic     pick_vld;
    logic     gnt;
    owner_t   winner;
    ram_req_t cpu_r;
    ram_req_t dbg_r;
    ram_req_t win_r;

    rr_pick2 #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_pick (
        .c          (cpu_req_i & cpu_rst_n_i),
        .d          (dbg_req_i),
        .last_owner (last_owner),
        .burst_cnt  (burst_cnt),
        .lock       (dbg_lock_i),
        .vld        (pick_vld),
        .winner     (winner)
    );

    assign gnt       = arb_en & pick_vld;
    assign cpu_gnt_o = gnt & (winner == OWN_CPU);
    assign dbg_gnt_o = gnt & (winner == OWN_DBG);

    always_comb begin
        cpu_r.we      = cpu_we_i;
        cpu_r.addr    = DATA_W'(cpu_addr_i);
        cpu_r.wr_data = DATA_W'(cpu_wr_data_i);
        cpu_r.byte_en = cpu_byte_en_i;
        dbg_r.we      = dbg_we_i;
        dbg_r.addr    = DATA_W'(dbg_addr_i);
        dbg_r.wr_data = DATA_W'(dbg_wr_data_i);
        dbg_r.byte_en = dbg_byte_en_i;
        // Idle cycles leave the debug fields on the port.
        win_r         = cpu_gnt_o ? cpu_r : dbg_r;
    end

    assign ram_rd_addr_o    = XLEN'(win_r.addr);
    assign ram_wr_addr_o    = XLEN'(win_r.addr);
    assign ram_wr_data_o    = XLEN'(win_r.wr_data);
    assign ram_wr_byte_en_o = (gnt && win_r.we) ? win_r.byte_en : 4'h0;

    assign cpu_rd_vld_o  = rd_pend[0];
    assign dbg_rd_vld_o  = rd_pend[1];
    assign cpu_rd_data_o = ram_rd_data_i;
    assign dbg_rd_data_o = ram_rd_data_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n_i) begin
            arb_en     <= 1'b0;
            last_owner <= OWN_CPU;
            burst_cnt  <= '0;
            rd_pend    <= '0;
        end else begin
            arb_en  <= 1'b1;
            rd_pend <= {dbg_gnt_o & ~dbg_we_i, cpu_gnt_o & ~cpu_we_i};
            if (gnt) begin
                if (winner == last_owner) begin
                    if (burst_cnt != CNT_W'(MAX_BURST))
                        burst_cnt <= burst_cnt + CNT_W'(1);
                end else begin
                    last_owner <= winner;
                    burst_cnt  <= CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_arb.sv
// Directed bench for ram_arb: reset release, burst cap, read return, debug
// lock, CPU masking and reset during a read return.
module tb_ram_arb;

    logic        clk;
    logic        rst_n;
    logic        cpu_rst_n;
    logic        dbg_lock;
    logic        cpu_req, dbg_req;
    logic        cpu_we, dbg_we;
    logic [31:0] cpu_addr, dbg_addr;
    logic [31:0] cpu_wr_data, dbg_wr_data;
    logic [3:0]  cpu_byte_en, dbg_byte_en;
    logic        cpu_gnt, dbg_gnt;
    logic        cpu_rd_vld, dbg_rd_vld;
    logic [31:0] cpu_rd_data, dbg_rd_data;
    logic [31:0] ram_rd_addr, ram_wr_addr, ram_wr_data;
    logic [3:0]  ram_wr_byte_en;
    logic [31:0] ram_rd_data;

    int checks   = 0;
    int failures = 0;

    ram_arb #(.XLEN(32), .MAX_BURST(8)) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .cpu_rst_n_i      (cpu_rst_n),
        .dbg_lock_i       (dbg_lock),
        .cpu_req_i        (cpu_req),
        .dbg_req_i        (dbg_req),
        .cpu_we_i         (cpu_we),
        .dbg_we_i         (dbg_we),
        .cpu_addr_i       (cpu_addr),
        .dbg_addr_i       (dbg_addr),
        .cpu_wr_data_i    (cpu_wr_data),
        .dbg_wr_data_i    (dbg_wr_data),
        .cpu_byte_en_i    (cpu_byte_en),
        .dbg_byte_en_i    (dbg_byte_en),
        .cpu_gnt_o        (cpu_gnt),
        .dbg_gnt_o        (dbg_gnt),
        .cpu_rd_vld_o     (cpu_rd_vld),
        .dbg_rd_vld_o     (dbg_rd_vld),
        .cpu_rd_data_o    (cpu_rd_data),
        .dbg_rd_data_o    (dbg_rd_data),
        .ram_rd_addr_o    (ram_rd_addr),
        .ram_wr_addr_o    (ram_wr_addr),
        .ram_wr_data_o    (ram_wr_data),
        .ram_wr_byte_en_o (ram_wr_byte_en),
        .ram_rd_data_i    (ram_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change just after a rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_dbg;
        int n_cpu;
        bit found;

        rst_n       = 1'b0;
        cpu_rst_n   = 1'b1;
        dbg_lock    = 1'b0;
        cpu_req     = 1'b0;
        cpu_we      = 1'b1;
        cpu_addr    = 32'h0000_0040;
        cpu_wr_data = 32'hCAFE_0000;
        cpu_byte_en = 4'h3;
        dbg_req     = 1'b1;
        dbg_we      = 1'b1;
        dbg_addr    = 32'h0000_0100;
        dbg_wr_data = 32'hA5A5_5A5A;
        dbg_byte_en = 4'hF;
        ram_rd_data = 32'h0;

        // Reset release with debug request held throughout.
        repeat (2) tick();
        @(negedge clk);
        check("rst_dbg_gnt", dbg_gnt, 0);
        check("rst_byte_en", ram_wr_byte_en, 4'h0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_edge1_gnt", dbg_gnt, 0);
        check("rel_edge1_byte_en", ram_wr_byte_en, 4'h0);
        tick();
        @(negedge clk);
        check("rel_edge2_gnt", dbg_gnt, 1);
        check("rel_edge2_byte_en", ram_wr_byte_en, 4'hF);
        check("rel_edge2_addr", ram_wr_addr, 32'h0000_0100);
        tick();

        // Burst cap: debug owned last, one lone CPU grant, then both request.
        for (int i = 0; i < 40; i++) begin
            cpu_req = 1'b1;
            dbg_req = (i != 0);
            @(negedge clk);
            check($sformatf("burst_%0d", i), {30'd0, cpu_gnt, dbg_gnt},
                  ((i / 8) % 2 == 0) ? 32'd2 : 32'd1);
            tick();
        end

        // CPU read latency.
        dbg_req  = 1'b0;
        cpu_we   = 1'b0;
        cpu_addr = 32'h8000_0010;
        @(negedge clk);
        check("rd_cpu_gnt", cpu_gnt, 1);
        check("rd_addr", ram_rd_addr, 32'h8000_0010);
        check("rd_byte_en", ram_wr_byte_en, 4'h0);
        tick();
        cpu_req     = 1'b0;
        ram_rd_data = 32'hDEAD_BEEF;
        @(negedge clk);
        check("rd_cpu_vld", cpu_rd_vld, 1);
        check("rd_cpu_data", cpu_rd_data, 32'hDEAD_BEEF);
        check("rd_dbg_vld", dbg_rd_vld, 0);
        tick();
        @(negedge clk);
        check("rd_cpu_vld_drop", cpu_rd_vld, 0);
        tick();

        // Debug lock: debug takes the port, then holds it against the CPU.
        cpu_we   = 1'b1;
        dbg_we   = 1'b1;
        dbg_req  = 1'b1;
        dbg_lock = 1'b1;
        @(negedge clk);
        check("lock_take", dbg_gnt, 1);
        tick();
        cpu_req = 1'b1;
        n_dbg   = 0;
        n_cpu   = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (dbg_gnt) n_dbg++;
            if (cpu_gnt) n_cpu++;
            tick();
        end
        check("lock_dbg_grants", n_dbg, 20);
        check("lock_cpu_grants", n_cpu, 0);
        dbg_lock = 1'b0;
        found    = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            @(negedge clk);
            if (cpu_gnt) found = 1'b1;
            tick();
        end
        check("lock_release_cpu", found, 1);

        // A granted CPU read still returns after the CPU is masked.
        dbg_req = 1'b0;
        cpu_we  = 1'b0;
        @(negedge clk);
        check("mask_rd_gnt", cpu_gnt, 1);
        tick();
        cpu_rst_n = 1'b0;
        @(negedge clk);
        check("mask_rd_vld", cpu_rd_vld, 1);
        check("mask_cpu_gnt", cpu_gnt, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("mask_idle_%0d", k), cpu_gnt, 0);
            tick();
        end
        dbg_req     = 1'b1;
        dbg_we      = 1'b1;
        dbg_wr_data = 32'h1122_3344;
        dbg_byte_en = 4'b0101;
        @(negedge clk);
        check("mask_dbg_gnt", dbg_gnt, 1);
        check("mask_cpu_gnt2", cpu_gnt, 0);
        check("mask_byte_en", ram_wr_byte_en, 4'b0101);
        check("mask_wr_data", ram_wr_data, 32'h1122_3344);
        tick();

        // Reset during a debug read's return cycle.
        cpu_req   = 1'b0;
        cpu_rst_n = 1'b1;
        dbg_we    = 1'b0;
        dbg_addr  = 32'h0000_0200;
        @(negedge clk);
        check("rstmid_gnt", dbg_gnt, 1);
        tick();
        dbg_req     = 1'b0;
        rst_n       = 1'b0;
        ram_rd_data = 32'h1234_5678;
        @(negedge clk);
        check("rstmid_vld_in_reset", dbg_rd_vld, 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rstmid_vld_after", dbg_rd_vld, 0);
        tick();
        dbg_req = 1'b1;
        dbg_we  = 1'b1;
        @(negedge clk);
        check("rstmid_solo_gnt", dbg_gnt, 1);
        tick();
        cpu_req = 1'b1;
        n_dbg   = 0;
        found   = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (cpu_gnt) found = 1'b1;
            else if (dbg_gnt) n_dbg++;
            tick();
        end
        check("rstmid_cpu_seen", found, 1);
        check("rstmid_dbg_run", n_dbg, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
